// File: rtl/sisc_pkg.sv
// Shared SISC core definitions: datapath widths, the fetch FSM state type
// and the word-address increment used by the fetch unit.
package sisc_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;

  typedef enum logic [1:0] {
    FS_IDLE,
    FS_WAIT,
    FS_DROP
  } fetch_state_e;

  // Word addresses wrap from all-ones back to zero.
  function automatic logic [ADDR_W-1:0] nextWordAddr(input logic [ADDR_W-1:0] addr);
    return addr + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/ifetch_if.sv
// Fetch-unit bus: instruction-memory req/ack side plus the instruction
// register / branch-control side. The master modport is the fetch unit.
interface ifetch_if;
  import sisc_pkg::*;

  logic                mem_req;
  logic [ADDR_W-1:0]   mem_addr;
  logic                mem_ack;
  logic [INSTR_W-1:0]  mem_data;
  logic                instr_vld;
  logic [INSTR_W-1:0]  instr_out;
  logic [ADDR_W-1:0]   instr_pc;
  logic                ir_load;
  logic                redirect;
  logic [ADDR_W-1:0]   redirect_addr;
  logic                halt;

  modport master (
    output mem_req, mem_addr, instr_vld, instr_out, instr_pc,
    input  mem_ack, mem_data, ir_load, redirect, redirect_addr, halt
  );

  modport slave (
    input  mem_req, mem_addr, instr_vld, instr_out, instr_pc,
    output mem_ack, mem_data, ir_load, redirect, redirect_addr, halt
  );

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch queue of {address, instruction} entries with a synchronous flush.
// Simultaneous push and pop are accepted at any fill level, including full.
module fetch_fifo
  import sisc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic                      clk,
  input  logic                      rst_f,
  input  logic                      flush_i,
  input  logic                      push_i,
  input  logic [ADDR_W+INSTR_W-1:0] wdata_i,
  input  logic                      pop_i,
  output logic [ADDR_W+INSTR_W-1:0] rdata_o,
  output logic [CW-1:0]             count_o,
  output logic                      full_o,
  output logic                      empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [ADDR_W+INSTR_W-1:0] store_q [DEPTH];
  logic [PW-1:0]             wrPtr_q;
  logic [PW-1:0]             rdPtr_q;
  logic [CW-1:0]             count_q;

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wrPtr_q <= wrPtr_q + PW'(1);
      if (pop_i)  rdPtr_q <= rdPtr_q + PW'(1);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage carries no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) store_q[wrPtr_q] <= wdata_i;
  end

  assign rdata_o = store_q[rdPtr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == DEPTH_C);
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/ifetch.sv
// Instruction fetch unit: req/ack fetch FSM, address counter and prefetch queue.
// Define FETCH_BYPASS_EN to forward an acked word straight out when the queue is empty.
module ifetch
  import sisc_pkg::*;
#(
  parameter int               DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic       clk,
  input logic       rst_f,
  ifetch_if.master  bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_state_e              state_q;
  logic                      req_q;
  logic [ADDR_W-1:0]         addr_q;
  logic [ADDR_W-1:0]         pendAddr_q;

  logic                      ackFire;
  logic                      bypass;
  logic                      bypassTake;
  logic                      pushEn;
  logic                      popEn;
  logic [CW-1:0]             count;
  logic [CW-1:0]             countNext;
  logic                      empty;
  logic                      full;
  logic [ADDR_W+INSTR_W-1:0] headEntry;

  assign ackFire = req_q && bus.mem_ack;

`ifdef FETCH_BYPASS_EN
  assign bypass = empty && (state_q == FS_WAIT) && ackFire && !bus.redirect;
`else
  assign bypass = 1'b0;
`endif

  assign bypassTake = bypass && bus.ir_load;
  assign pushEn     = (state_q == FS_WAIT) && ackFire && !bypassTake;
  assign popEn      = bus.ir_load && !empty;
  assign countNext  = count + CW'(pushEn) - CW'(popEn);

  fetch_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk     (clk),
    .rst_f   (rst_f),
    .flush_i (bus.redirect),
    .push_i  (pushEn),
    .wdata_i ({addr_q, bus.mem_data}),
    .pop_i   (popEn),
    .rdata_o (headEntry),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  // In FS_DROP mem_addr must hold the outstanding address, so the redirect
  // target waits in pendAddr_q until the stale ack arrives.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_q    <= FS_IDLE;
      req_q      <= 1'b0;
      addr_q     <= RESET_PC;
      pendAddr_q <= RESET_PC;
    end else if (bus.redirect) begin
      case (state_q)
        FS_WAIT: begin
          if (ackFire) begin
            state_q <= FS_IDLE;
            req_q   <= 1'b0;
            addr_q  <= bus.redirect_addr;
          end else begin
            state_q    <= FS_DROP;
            pendAddr_q <= bus.redirect_addr;
          end
        end
        FS_DROP: begin
          if (ackFire) begin
            addr_q <= bus.redirect_addr;
            if (!bus.halt) begin
              state_q <= FS_WAIT;
              req_q   <= 1'b1;
            end else begin
              state_q <= FS_IDLE;
              req_q   <= 1'b0;
            end
          end else begin
            pendAddr_q <= bus.redirect_addr;
          end
        end
        default: begin
          state_q <= FS_IDLE;
          req_q   <= 1'b0;
          addr_q  <= bus.redirect_addr;
        end
      endcase
    end else begin
      case (state_q)
        FS_IDLE: begin
          if (!bus.halt && !full) begin
            state_q <= FS_WAIT;
            req_q   <= 1'b1;
          end
        end
        FS_WAIT: begin
          if (ackFire) begin
            addr_q <= nextWordAddr(addr_q);
            if (!bus.halt && (countNext < DEPTH_C)) begin
              state_q <= FS_WAIT;
              req_q   <= 1'b1;
            end else begin
              state_q <= FS_IDLE;
              req_q   <= 1'b0;
            end
          end
        end
        FS_DROP: begin
          if (ackFire) begin
            addr_q <= pendAddr_q;
            if (!bus.halt && (countNext < DEPTH_C)) begin
              state_q <= FS_WAIT;
              req_q   <= 1'b1;
            end else begin
              state_q <= FS_IDLE;
              req_q   <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= FS_IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_req  = req_q;
  assign bus.mem_addr = addr_q;

  always_comb begin
    bus.instr_vld = !empty;
    bus.instr_out = empty ? '0 : headEntry[INSTR_W-1:0];
    bus.instr_pc  = empty ? '0 : headEntry[ADDR_W+INSTR_W-1:INSTR_W];
    if (bypass) begin
      bus.instr_vld = 1'b1;
      bus.instr_out = bus.mem_data;
      bus.instr_pc  = addr_q;
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// Directed self-checking bench for ifetch (DEPTH=4). Memory returns
// mem_addr ^ 32'h5A5A0000; expected values below are worked out by hand.
module tb_ifetch;
  import sisc_pkg::*;

  logic clk;
  logic rst_f;
  int   assertCount;
  int   failCount;

  ifetch_if bus ();

  ifetch #(
    .DEPTH    (4),
    .RESET_PC (32'h0)
  ) dut (
    .clk   (clk),
    .rst_f (rst_f),
    .bus   (bus)
  );

  assign bus.mem_data = bus.mem_addr ^ 32'h5A5A_0000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic ack, input logic ld, input logic redir,
                               input logic [31:0] raddr, input logic hlt);
    bus.mem_ack       = ack;
    bus.ir_load       = ld;
    bus.redirect      = redir;
    bus.redirect_addr = raddr;
    bus.halt          = hlt;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    assertCount       = 0;
    failCount         = 0;
    rst_f             = 1'b0;
    bus.mem_ack       = 1'b0;
    bus.ir_load       = 1'b0;
    bus.redirect      = 1'b0;
    bus.redirect_addr = 32'h0;
    bus.halt          = 1'b0;

    #2;
    checkOutput("rst_req",  32'(bus.mem_req),   32'h0);
    checkOutput("rst_addr", bus.mem_addr,       32'h0);
    checkOutput("rst_vld",  32'(bus.instr_vld), 32'h0);
    checkOutput("rst_out",  bus.instr_out,      32'h0);
    checkOutput("rst_pc",   bus.instr_pc,       32'h0);
    #10;
    rst_f = 1'b1;

    // Zero-wait fill, no pops
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("fill_req0",  32'(bus.mem_req),   32'h1);
    checkOutput("fill_addr0", bus.mem_addr,       32'h0);
    checkOutput("fill_vld0",  32'(bus.instr_vld), 32'h0);
    for (int i = 1; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      checkOutput("fill_addr", bus.mem_addr, 32'(i));
      checkOutput("fill_req",  32'(bus.mem_req), 32'h1);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("full_req",   32'(bus.mem_req),   32'h0);
    checkOutput("full_addr",  bus.mem_addr,       32'h4);
    checkOutput("full_count", 32'(dut.count),     32'h4);
    checkOutput("full_out",   bus.instr_out,      32'h5A5A_0000);
    checkOutput("full_pc",    bus.instr_pc,       32'h0);
    checkOutput("full_vld",   32'(bus.instr_vld), 32'h1);

    // One pop at full frees a slot, refetch of word 4
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("pop_out",   bus.instr_out,  32'h5A5A_0001);
    checkOutput("pop_pc",    bus.instr_pc,   32'h1);
    checkOutput("pop_count", 32'(dut.count), 32'h3);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("refetch_req",  32'(bus.mem_req), 32'h1);
    checkOutput("refetch_addr", bus.mem_addr,     32'h4);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("refill_count", 32'(dut.count),   32'h4);
    checkOutput("refill_req",   32'(bus.mem_req), 32'h0);
    checkOutput("refill_out",   bus.instr_out,    32'h5A5A_0001);

    // Drain under halt
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    checkOutput("drain_pc2", bus.instr_pc, 32'h2);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    checkOutput("drain_out3", bus.instr_out, 32'h5A5A_0003);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    checkOutput("drain_pc4", bus.instr_pc, 32'h4);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    checkOutput("empty_vld", 32'(bus.instr_vld), 32'h0);
    checkOutput("empty_out", bus.instr_out,      32'h0);
    checkOutput("empty_pc",  bus.instr_pc,       32'h0);
    checkOutput("halt_req",  32'(bus.mem_req),   32'h0);

    // Slow memory, redirect to 0x40 while waiting
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("slow_req",  32'(bus.mem_req), 32'h1);
    checkOutput("slow_addr", bus.mem_addr,     32'h5);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h40, 1'b0);
    checkOutput("drop_state", 32'(dut.state_q), 32'(FS_DROP));
    checkOutput("drop_addr",  bus.mem_addr,     32'h5);
    checkOutput("drop_req",   32'(bus.mem_req), 32'h1);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("stale_vld", 32'(bus.instr_vld), 32'h0);
    checkOutput("redir_addr", bus.mem_addr,      32'h40);
    checkOutput("redir_req",  32'(bus.mem_req),  32'h1);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("redir_pc",   bus.instr_pc,  32'h40);
    checkOutput("redir_out",  bus.instr_out, 32'h5A5A_0040);
    checkOutput("redir_next", bus.mem_addr,  32'h41);

    // Redirect and ack on the same edge
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h80, 1'b0);
    checkOutput("same_state", 32'(dut.state_q),  32'(FS_IDLE));
    checkOutput("same_vld",   32'(bus.instr_vld), 32'h0);
    checkOutput("same_out",   bus.instr_out,      32'h0);
    checkOutput("same_req",   32'(bus.mem_req),   32'h0);
    checkOutput("same_addr",  bus.mem_addr,       32'h80);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("rereq_req", 32'(bus.mem_req),   32'h1);
    checkOutput("rereq_vld", 32'(bus.instr_vld), 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("rereq_pc",  bus.instr_pc,  32'h80);
    checkOutput("rereq_out", bus.instr_out, 32'h5A5A_0080);

    // Halt with a request outstanding
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("hold_req",  32'(bus.mem_req), 32'h1);
    checkOutput("hold_addr", bus.mem_addr,     32'h81);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("hdone_req",   32'(bus.mem_req), 32'h0);
    checkOutput("hdone_count", 32'(dut.count),   32'h2);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("hlate_req",   32'(bus.mem_req), 32'h0);
    checkOutput("hlate_count", 32'(dut.count),   32'h2);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("unhalt_req",  32'(bus.mem_req), 32'h1);
    checkOutput("unhalt_addr", bus.mem_addr,     32'h82);

    // Address wrap at all-ones
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0);
    checkOutput("wrapdrop_vld", 32'(bus.instr_vld), 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("wrap_addr_hi", bus.mem_addr, 32'hFFFF_FFFF);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("wrap_addr_lo", bus.mem_addr,  32'h0);
    checkOutput("wrap_pc",      bus.instr_pc,  32'hFFFF_FFFF);
    checkOutput("wrap_out",     bus.instr_out, 32'hA5A5_FFFF);

    // Second redirect while already dropping retargets the fetch
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h200, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h100, 1'b0);
    checkOutput("redrop_state", 32'(dut.state_q), 32'(FS_DROP));
    checkOutput("redrop_addr",  bus.mem_addr,     32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("retarget_addr", bus.mem_addr, 32'h100);

    // Empty queue, ack and ir_load in the same cycle
    bus.mem_ack = 1'b1;
    bus.ir_load = 1'b1;
    #1;
`ifdef FETCH_BYPASS_EN
    checkOutput("byp_vld", 32'(bus.instr_vld), 32'h1);
    checkOutput("byp_out", bus.instr_out,      32'h5A5A_0100);
    checkOutput("byp_pc",  bus.instr_pc,       32'h100);
`else
    checkOutput("byp_vld", 32'(bus.instr_vld), 32'h0);
    checkOutput("byp_out", bus.instr_out,      32'h0);
    checkOutput("byp_pc",  bus.instr_pc,       32'h0);
`endif
    @(posedge clk);
    #1;
`ifdef FETCH_BYPASS_EN
    checkOutput("byp_count", 32'(dut.count), 32'h0);
`else
    checkOutput("byp_count", 32'(dut.count), 32'h1);
`endif
    checkOutput("byp_addr", bus.mem_addr, 32'h101);

    // Reset mid-transaction with a late ack
    bus.ir_load = 1'b0;
    #3;
    rst_f = 1'b0;
    #1;
    checkOutput("mrst_req",   32'(bus.mem_req),   32'h0);
    checkOutput("mrst_addr",  bus.mem_addr,       32'h0);
    checkOutput("mrst_vld",   32'(bus.instr_vld), 32'h0);
    checkOutput("mrst_count", 32'(dut.count),     32'h0);
    @(posedge clk);
    #3;
    rst_f = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("post_req",   32'(bus.mem_req), 32'h1);
    checkOutput("post_count", 32'(dut.count),   32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("post_out", bus.instr_out, 32'h5A5A_0000);
    checkOutput("post_pc",  bus.instr_pc,  32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
